// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receive side of a multiplexed 7-segment display bus. The display driver
// strobes one digit at a time on `sel` and puts the segment pattern for that
// digit on `dis`. This block waits for the bus to settle, samples each digit
// once per dwell, decodes the glyph back to a hex value and publishes a
// complete frame once every digit position has been captured.
//
// Parameters
//   N_DIG        number of scanned digits (width of sel)
//   SEL_ACT_LOW  1: a low sel bit selects its digit, 0: a high bit selects it
//   SEG_ACT_LOW  1: a low dis bit lights its segment, 0: a high bit lights it
//   STABLE_CYC   cycles {sel,dis} must hold before it is sampled (>= 2)
//
// Ports
//   clk          rising-edge system clock
//   rstn         synchronous reset, active low
//   sel          digit strobes from the display driver
//   dis          segment lines, [0]=a .. [6]=g, [7]=dp
//   digits       last complete frame, digit i at [4i+3:4i]
//   dp           decimal point of each digit in the last frame
//   digit_ok     1 = digit i carried a legal hex glyph
//   frame_valid  one-cycle pulse when digits/dp/digit_ok update
//   scan_err     one-cycle pulse when a stable sel has more than one digit active
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int N_DIG       = 8,
    parameter int SEL_ACT_LOW = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int STABLE_CYC  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_DIG-1:0]     sel,
    input  logic [7:0]           dis,
    output logic [4*N_DIG-1:0]   digits,
    output logic [N_DIG-1:0]     dp,
    output logic [N_DIG-1:0]     digit_ok,
    output logic                 frame_valid,
    output logic                 scan_err
);

    // Counter only has to reach STABLE_CYC-1; keep at least one bit.
    localparam int            CW      = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // -------------------------------------------------------------------------
    // Glyph decode: returns {legal, value}. Unknown patterns give value 0 and
    // legal 0. Pattern bit order is gfedcba.
    // -------------------------------------------------------------------------
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h27:   res = {1'b1, 4'h7};   // alternate 7 with segment f lit
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // True when exactly one bit of the strobe vector is set.
    function automatic logic is_onehot(input logic [N_DIG-1:0] v);
        logic [N_DIG-1:0] lower;
        lower = v - N_DIG'(1);
        return (v != {N_DIG{1'b0}}) && ((v & lower) == {N_DIG{1'b0}});
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N_DIG-1:0]        s_in_s;
    logic [7:0]              p_in_s;

    logic [N_DIG-1:0]        s_q,        s_d;
    logic [7:0]              p_q,        p_d;
    logic [N_DIG-1:0]        s_prev_q,   s_prev_d;
    logic [7:0]              p_prev_q,   p_prev_d;
    logic [CW-1:0]           cnt_q,      cnt_d;
    logic                    captured_q, captured_d;

    logic [N_DIG-1:0][3:0]   stg_val_q,  stg_val_d;
    logic [N_DIG-1:0]        dp_stg_q,   dp_stg_d;
    logic [N_DIG-1:0]        ok_stg_q,   ok_stg_d;
    logic [N_DIG-1:0]        seen_q,     seen_d;

    logic [N_DIG-1:0][3:0]   digits_q,   digits_d;
    logic [N_DIG-1:0]        dp_q,       dp_d;
    logic [N_DIG-1:0]        ok_q,       ok_d;
    logic                    fv_q,       fv_d;
    logic                    err_q,      err_d;

    logic                    change_s;
    logic                    sample_s;
    logic [4:0]              dec_s;
    logic [N_DIG-1:0]        seen_nx_s;

    // Normalise strobes and segments to active-high before registering.
    always_comb begin
        s_in_s = sel;
        p_in_s = dis;
        if (SEL_ACT_LOW != 0) begin
            s_in_s = ~sel;
        end else begin
            s_in_s = sel;
        end
        if (SEG_ACT_LOW != 0) begin
            p_in_s = ~dis;
        end else begin
            p_in_s = dis;
        end
    end

    // Next-state logic: stability tracking, sampling, staging and frame publish.
    always_comb begin
        s_d        = s_in_s;
        p_d        = p_in_s;
        s_prev_d   = s_q;
        p_prev_d   = p_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        stg_val_d  = stg_val_q;
        dp_stg_d   = dp_stg_q;
        ok_stg_d   = ok_stg_q;
        seen_d     = seen_q;
        digits_d   = digits_q;
        dp_d       = dp_q;
        ok_d       = ok_q;
        fv_d       = 1'b0;
        err_d      = 1'b0;
        seen_nx_s  = seen_q;

        dec_s    = decode_glyph(p_q[6:0]);
        change_s = (s_q != s_prev_q) || (p_q != p_prev_q);

        // Any movement on the bus restarts the dwell and re-arms sampling.
        if (change_s) begin
            cnt_d      = {CW{1'b0}};
            captured_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        // Sample on the edge where the counter reaches its ceiling, so the
        // staged value and (for the last digit) the published frame appear
        // together; captured_q keeps long dwells from sampling twice.
        sample_s = !change_s && (cnt_d == CNT_MAX) && !captured_q;

        if (sample_s) begin
            captured_d = 1'b1;
            if (is_onehot(s_q)) begin
                for (int i = 0; i < N_DIG; i++) begin
                    if (s_q[i]) begin
                        stg_val_d[i] = dec_s[3:0];
                        dp_stg_d[i]  = p_q[7];
                        ok_stg_d[i]  = dec_s[4];
                    end else begin
                        stg_val_d[i] = stg_val_q[i];
                        dp_stg_d[i]  = dp_stg_q[i];
                        ok_stg_d[i]  = ok_stg_q[i];
                    end
                end
                seen_nx_s = seen_q | s_q;
                // Publish from the updated staging so the final digit is included.
                if (seen_nx_s == {N_DIG{1'b1}}) begin
                    digits_d = stg_val_d;
                    dp_d     = dp_stg_d;
                    ok_d     = ok_stg_d;
                    fv_d     = 1'b1;
                    seen_d   = {N_DIG{1'b0}};
                end else begin
                    seen_d   = seen_nx_s;
                end
            end else if (s_q != {N_DIG{1'b0}}) begin
                // Two or more digits strobed at once: report, stage nothing.
                err_d = 1'b1;
            end else begin
                // Blanking gap between digits: nothing to capture.
                err_d = 1'b0;
            end
        end else begin
            captured_d = captured_d;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_q        <= '0;
            p_q        <= 8'h00;
            s_prev_q   <= '0;
            p_prev_q   <= 8'h00;
            cnt_q      <= '0;
            captured_q <= 1'b0;
            stg_val_q  <= '0;
            dp_stg_q   <= '0;
            ok_stg_q   <= '0;
            seen_q     <= '0;
            digits_q   <= '0;
            dp_q       <= '0;
            ok_q       <= '0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s_q        <= s_d;
            p_q        <= p_d;
            s_prev_q   <= s_prev_d;
            p_prev_q   <= p_prev_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            stg_val_q  <= stg_val_d;
            dp_stg_q   <= dp_stg_d;
            ok_stg_q   <= ok_stg_d;
            seen_q     <= seen_d;
            digits_q   <= digits_d;
            dp_q       <= dp_d;
            ok_q       <= ok_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign digit_ok    = ok_q;
    assign frame_valid = fv_q;
    assign scan_err    = err_q;

endmodule
